// File: rtl/mem_copy_ctrl.sv
// Word-by-word memory copy engine: reads src, writes dst, two cycles per word.
// Pointers wrap modulo DEPTH; abort and async reset abandon the copy silently.
module mem_copy_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       src_addr,
  input  logic [31:0]       dst_addr,
  input  logic [ADDR_W:0]   word_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   words_done,
  output logic [31:0]       address,
  output logic [31:0]       write_data,
  output logic              MemWrite,
  output logic              MemRead,
  input  logic [31:0]       read_data
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_FINISH
  } state_t;

  localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH-1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [ADDR_W:0]   r_rem;
  logic [ADDR_W:0]   r_words;
  logic [31:0]       r_hold;
  logic              r_busy;
  logic              r_done;

  logic [ADDR_W:0]   w_cnt_sat;
  logic              w_unused;

  function automatic logic [ADDR_W-1:0] f_inc(
    input logic [ADDR_W-1:0] p
  );
    return (p == LP_LAST) ? '0 : p + ADDR_W'(1);
  endfunction

  assign w_cnt_sat = (word_count > LP_DEPTH) ? LP_DEPTH : word_count;
  assign w_unused  = ^{src_addr[31:ADDR_W], dst_addr[31:ADDR_W]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_src   <= '0;
      r_dst   <= '0;
      r_rem   <= '0;
      r_words <= '0;
      r_hold  <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            if (word_count != '0) begin
              r_src   <= src_addr[ADDR_W-1:0];
              r_dst   <= dst_addr[ADDR_W-1:0];
              r_rem   <= w_cnt_sat;
              r_words <= '0;
              r_busy  <= 1'b1;
              r_state <= S_READ;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end
          end
        end
        S_READ: begin
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_hold  <= read_data;
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          // the write itself still happens this cycle; abort only
          // suppresses the bookkeeping and the next read
          if (abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_src   <= f_inc(r_src);
            r_dst   <= f_inc(r_dst);
            r_words <= r_words + (ADDR_W+1)'(1);
            r_rem   <= r_rem - (ADDR_W+1)'(1);
            if (r_rem == (ADDR_W+1)'(1)) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_FINISH;
            end else begin
              r_state <= S_READ;
            end
          end
        end
        S_FINISH: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign words_done = r_words;
  assign MemRead    = (r_state == S_READ);
  assign MemWrite   = (r_state == S_WRITE);

  assign address =
    (r_state == S_READ)  ? {{(32-ADDR_W){1'b0}}, r_src} :
    (r_state == S_WRITE) ? {{(32-ADDR_W){1'b0}}, r_dst} :
    32'd0;

  assign write_data = (r_state == S_WRITE) ? r_hold : 32'd0;

endmodule

// File: tb/tb_mem_copy_ctrl.sv
// Bench for mem_copy_ctrl: memory model, read/write scoreboard,
// vector table of copies plus abort, zero-count, re-start and reset sequences.
module tb_mem_copy_ctrl;

  localparam int AW = 8;
  localparam int DP = 256;

  logic          clk;
  logic          rst;
  logic          start;
  logic          abort;
  logic [31:0]   src_addr;
  logic [31:0]   dst_addr;
  logic [AW:0]   word_count;
  logic          busy;
  logic          done;
  logic [AW:0]   words_done;
  logic [31:0]   address;
  logic [31:0]   write_data;
  logic          MemWrite;
  logic          MemRead;
  logic [31:0]   read_data;

  mem_copy_ctrl #(.ADDR_W(AW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .word_count (word_count),
    .busy       (busy),
    .done       (done),
    .words_done (words_done),
    .address    (address),
    .write_data (write_data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .read_data  (read_data)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    int src;
    int dst;
    int cnt;
    int nwords;
    int done_off;
  } vec_t;

  logic [31:0] mem [DP];
  logic [31:0] sh  [DP];
  int          rq [$];
  wr_t         wq [$];
  vec_t        vt [6];

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_done = 0;
  int done_cyc = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  bit busy_seen = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (MemWrite) mem[address[7:0]] <= write_data;

  assign read_data = mem[address[7:0]];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_evt(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s: event occurred, expected none", nm);
  endtask

  // per-cycle checkers and scoreboard consumer
  int  m_ea;
  wr_t m_ew;
  always @(negedge clk) begin
    chk("strobe_excl", MemRead & MemWrite, 0);
    chk("addr_upper", address[31:8], 0);
    if (busy) busy_seen = 1;
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (MemRead) begin
      rd_cnt++;
      if (rq.size() == 0) fail_evt("unexpected_rd");
      else begin
        m_ea = rq.pop_front();
        chk("rd_addr", address, m_ea);
      end
    end
    if (MemWrite) begin
      wr_cnt++;
      if (wq.size() == 0) fail_evt("unexpected_wr");
      else begin
        m_ew = wq.pop_front();
        chk("wr_addr", address, m_ew.a);
        chk("wr_data", write_data, m_ew.d);
      end
    end
  end

  function automatic int mem_diff();
    int n = 0;
    for (int i = 0; i < DP; i++)
      if (mem[i] !== sh[i]) n++;
    return n;
  endfunction

  task automatic push_model(input int s, input int d, input int n);
    for (int i = 0; i < n; i++) begin
      int  a;
      int  b;
      wr_t w;
      a = (s + i) % DP;
      b = (d + i) % DP;
      rq.push_back(a);
      w.a = b;
      w.d = sh[a];
      wq.push_back(w);
      sh[b] = sh[a];
    end
  endtask

  task automatic start_copy(input int s, input int d, input int c,
                            output int k);
    @(negedge clk);
    src_addr   = s;
    dst_addr   = d;
    word_count = 9'(c);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = cyc;
  endtask

  task automatic wait_done(input int n0, input int bound, output bit ok);
    ok = 0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      #1;
      if (n_done > n0) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v);
    int k;
    int n0;
    bit ok;
    n0 = n_done;
    busy_seen = 0;
    push_model(v.src, v.dst, v.nwords);
    start_copy(v.src, v.dst, v.cnt, k);
    wait_done(n0, 2 * v.nwords + 20, ok);
    chk("done_seen", ok, 1);
    if (ok) chk("latency", done_cyc + 1 - k, v.done_off);
    repeat (3) @(negedge clk);
    #1;
    chk("single_done", n_done - n0, 1);
    chk("words_done", words_done, v.nwords);
    chk("busy_after", busy, 0);
    chk("busy_seen", busy_seen, 1);
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    chk("mem_image", mem_diff(), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int  k;
    int  n0;
    bit  ok;
    vec_t v1;

    vt[0] = '{0,   10,  3,   3,   7};
    vt[1] = '{254, 100, 4,   4,   9};
    vt[2] = '{20,  22,  4,   4,   9};
    vt[3] = '{40,  38,  3,   3,   7};
    vt[4] = '{0,   200, 1,   1,   3};
    vt[5] = '{0,   128, 300, 256, 513};

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    word_count = '0;
    for (int i = 0; i < DP; i++) begin
      mem[i] = (i < 6) ? 32'(i) : 32'h1000 + 32'(i * 3);
      sh[i]  = mem[i];
    end
    #1;
    chk("rst_ctrl", {busy, done, MemRead, MemWrite, words_done}, 0);
    chk("rst_addr", address, 0);
    chk("rst_wdata", write_data, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_vec(vt[i]);
      if (i == 0) begin
        chk("mem10", mem[10], 0);
        chk("mem11", mem[11], 1);
        chk("mem12", mem[12], 2);
        for (int j = 0; j < 6; j++) chk("src_kept", mem[j], j);
      end
    end

    // zero-length copy
    n0 = n_done;
    rd_cnt = 0;
    wr_cnt = 0;
    busy_seen = 0;
    start_copy(5, 6, 0, k);
    wait_done(n0, 10, ok);
    chk("zero_done", ok, 1);
    if (ok) chk("zero_latency", done_cyc + 1 - k, 1);
    repeat (3) @(negedge clk);
    chk("zero_access", rd_cnt + wr_cnt, 0);
    chk("zero_busy", busy_seen, 0);

    // abort during the second write of a 5-word copy
    n0 = n_done;
    push_model(50, 60, 2);
    start_copy(50, 60, 5, k);
    repeat (3) @(posedge clk);
    #1;
    chk("abort_wd_pre", words_done, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_wd_post", words_done, 1);
    chk("abort_idle", {busy, MemRead, MemWrite}, 0);
    repeat (6) @(negedge clk);
    #1;
    chk("abort_no_done", n_done - n0, 0);
    chk("abort_wd_hold", words_done, 1);
    chk("abort_rq", rq.size(), 0);
    chk("abort_wq", wq.size(), 0);
    chk("abort_mem", mem_diff(), 0);
    v1 = '{60, 150, 2, 2, 5};
    run_vec(v1);

    // start pulsed while busy
    n0 = n_done;
    push_model(70, 80, 3);
    start_copy(70, 80, 3, k);
    @(negedge clk);
    src_addr = 0;
    dst_addr = 90;
    word_count = 9'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n0, 30, ok);
    chk("rebusy_done", ok, 1);
    if (ok) chk("rebusy_latency", done_cyc + 1 - k, 7);
    repeat (10) @(negedge clk);
    #1;
    chk("rebusy_single", n_done - n0, 1);
    chk("rebusy_wd", words_done, 3);
    chk("rebusy_rq", rq.size(), 0);
    chk("rebusy_wq", wq.size(), 0);
    chk("rebusy_mem", mem_diff(), 0);

    // asynchronous reset mid-READ
    n0 = n_done;
    start_copy(30, 90, 4, k);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_ctrl", {busy, done, MemRead, MemWrite, words_done}, 0);
    chk("arst_addr", address, 0);
    chk("arst_wdata", write_data, 0);
    #1;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("arst_idle", {busy, MemRead, MemWrite}, 0);
    chk("arst_no_done", n_done - n0, 0);
    chk("arst_rq", rq.size(), 0);
    chk("arst_mem", mem_diff(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_copy_ctrl.md
MEM_COPY_CTRL -- requirements
Module: mem_copy_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, giving the word-address width actually used on the memory port.
REQ-002 The block SHALL have parameter DEPTH, default 256, giving the number of 32-bit words in the attached data memory.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 The block SHALL have port clk, input, 1, rising-edge clock.
REQ-005 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port start, input, 1, single-cycle request to begin a copy.
REQ-007 The block SHALL have port abort, input, 1, cancels an in-progress copy.
REQ-008 The block SHALL have port src_addr, input, 32, first source word address; only bits [ADDR_W-1:0] are used.
REQ-009 The block SHALL have port dst_addr, input, 32, first destination word address; only bits [ADDR_W-1:0] are used.
REQ-010 The block SHALL have port word_count, input, ADDR_W+1, number of words to copy, 0..DEPTH.
REQ-011 The block SHALL have port busy, output, 1, high while a copy is in progress.
REQ-012 The block SHALL have port done, output, 1, one-cycle pulse on normal completion.
REQ-013 The block SHALL have port words_done, output, ADDR_W+1, count of words written so far.
REQ-014 The block SHALL have port address, output, 32, word address to data memory.
REQ-015 The block SHALL have port write_data, output, 32, store data to data memory.
REQ-016 The block SHALL have port MemWrite, output, 1, write strobe to data memory.
REQ-017 The block SHALL have port MemRead, output, 1, read strobe to data memory.
REQ-018 The block SHALL have port read_data, input, 32, combinational read data from memory, valid in the same cycle as MemRead.

Function
REQ-019 The FSM SHALL have states IDLE, READ, WRITE and FINISH, all registered.
- IDLE: start=1 with word_count>0 latches src, dst and count, clears words_done, and moves to READ.
- IDLE: start=1 with word_count=0 moves to FINISH with no memory access.
REQ-020 In READ, the block SHALL drive MemRead=1 and address={zeros, src_ptr}, capture read_data into a 32-bit holding register at the clock edge, and move to WRITE.
REQ-021 In WRITE, the block SHALL drive MemWrite=1, address={zeros, dst_ptr} and write_data=holding register.
- At the edge ending WRITE, the block increments src_ptr, dst_ptr and words_done and decrements the remaining count.
- It then moves to READ if remaining>0, otherwise to FINISH.
REQ-022 FINISH SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-023 MemRead and MemWrite SHALL never both be 1.
- In IDLE and FINISH both strobes are 0, and address and write_data are 0.
REQ-024 Pointer arithmetic SHALL be modulo DEPTH: an ADDR_W-bit pointer wraps from DEPTH-1 to 0, and address bits [31:ADDR_W] are always 0.
REQ-025 busy SHALL be 1 in READ and WRITE and 0 in IDLE and FINISH.
REQ-026 Latency: for N>0 words, start sampled at edge k SHALL give done high during cycle k+2N+1, and the copy SHALL take 2 cycles per word.
REQ-027 start while busy or in FINISH SHALL be ignored.
REQ-028 abort=1 in READ or WRITE SHALL return the FSM to IDLE at the next edge with no done pulse and words_done holding its value.
- An abort in WRITE still completes that cycle's write, because the strobe is combinational from state.
- abort in IDLE or FINISH has no effect.
REQ-029 If start and abort are both 1 in IDLE, start SHALL take precedence.
REQ-030 Overlapping regions SHALL be copied strictly ascending, word by word, with no overlap correction.
- When dst>src inside the region, earlier-written words are re-read.
REQ-031 word_count values above DEPTH SHALL be saturated to DEPTH when latched.

Reset
REQ-032 While rst=1, asynchronously and regardless of clk, the block SHALL set:
- state=IDLE;
- busy=0, done=0, words_done=0;
- MemRead=0, MemWrite=0, address=0, write_data=0;
- holding register and all pointers to 0.
REQ-033 Reset asserted mid-copy SHALL abandon the copy with no done pulse, and the first cycle after release SHALL be IDLE.

Verification
REQ-034 The bench SHALL run: memory words 0..5 = 0..5; start with src=0, dst=10, count=3.
- Required: MEM[10..12] = 0,1,2; done pulses at cycle k+7; words_done=3; MEM[0..5] unchanged.
REQ-035 The bench SHALL run: start with count=0.
- Required: done at cycle k+1; no MemRead or MemWrite cycles; busy never 1.
REQ-036 The bench SHALL run: src=254, dst=100, count=4 with DEPTH=256.
- Required: reads from addresses 254, 255, 0, 1 and writes to 100..103, with the same values.
REQ-037 The bench SHALL run: abort during the 2nd WRITE of a 5-word copy.
- Required: 2 words written; words_done=1 then stays 1 (increment suppressed by abort); no done; IDLE next cycle; a following start succeeds.
REQ-038 The bench SHALL run: rst pulsed asynchronously mid-READ.
- Required: all outputs 0 immediately, before the next clk edge.
REQ-039 The bench SHALL run: start pulsed again while busy.
- Required: ignored; the original copy finishes with a single done pulse.
REQ-040 The bench SHALL run checkers every cycle for strobe exclusivity and zero upper address bits.
